// File: rtl/aes_pkg.sv
// Shared AES constants, S-box tables, FSM state type and ShiftRows index helpers.
// The inverse table is only referenced when AES_INV_SBOX_EN is defined.
package aes_pkg;

    localparam int STATE_W = 128;
    localparam int BYTE_W  = 8;
    localparam int NB      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_SBOX [0:255] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Source byte index in the working register for output byte i = 4c+r.
    function automatic int fwd_src_idx(input int i);
        int c;
        int r;
        c = i / NB;
        r = i % NB;
        return NB * ((c + r) % NB) + r;
    endfunction

    function automatic int inv_src_idx(input int i);
        int c;
        int r;
        c = i / NB;
        r = i % NB;
        return NB * ((c - r + NB) % NB) + r;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box lookup; the inverse select exists only with AES_INV_SBOX_EN.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] i_byte,
`ifdef AES_INV_SBOX_EN
    input  logic       i_inv,
`endif
    output logic [7:0] o_byte
);

`ifdef AES_INV_SBOX_EN
    assign o_byte = i_inv ? INV_SBOX[i_byte] : SBOX[i_byte];
`else
    assign o_byte = SBOX[i_byte];
`endif

endmodule

// File: rtl/aes_sub_shift.sv
// Iterative SubBytes (one column per cycle) + output-side ShiftRows for the AES round.
// Decrypt support (in_inv port, inverse S-box and inverse ShiftRows) is enabled by AES_INV_SBOX_EN.
module aes_sub_shift
    import aes_pkg::*;
#(
    parameter int STATE_W = aes_pkg::STATE_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_state,
`ifdef AES_INV_SBOX_EN
    input  logic               in_inv,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_state
);

    state_t             r_state;
    state_t             w_next;
    logic [1:0]         r_col;
    logic [STATE_W-1:0] r_work;
    logic [31:0]        w_col_in;
    logic [31:0]        w_col_sub;
    logic               w_accept;
`ifdef AES_INV_SBOX_EN
    logic               r_inv;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = BUSY;
            end
            BUSY: begin
                if (r_col == 2'd3) w_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_accept = (r_state == IDLE) && in_valid;
    assign w_col_in = r_work[{r_col, 5'd0} +: 32];

    // Column counter wraps 3 -> 0 on its own, which is also the state the next accept expects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col  <= 2'd0;
            r_work <= '0;
`ifdef AES_INV_SBOX_EN
            r_inv  <= 1'b0;
`endif
        end else if (w_accept) begin
            r_col  <= 2'd0;
            r_work <= in_state;
`ifdef AES_INV_SBOX_EN
            r_inv  <= in_inv;
`endif
        end else if (r_state == BUSY) begin
            r_col                       <= r_col + 2'd1;
            r_work[{r_col, 5'd0} +: 32] <= w_col_sub;
        end
    end

    for (genvar gr = 0; gr < NB; gr++) begin : g_sbox
        aes_sbox u_sbox (
            .i_byte (w_col_in[BYTE_W*gr +: BYTE_W]),
`ifdef AES_INV_SBOX_EN
            .i_inv  (r_inv),
`endif
            .o_byte (w_col_sub[BYTE_W*gr +: BYTE_W])
        );
    end

    // ShiftRows is pure wiring from the working register; no S-box sits on this path.
    for (genvar gi = 0; gi < STATE_W / BYTE_W; gi++) begin : g_shift
        localparam int FWD = fwd_src_idx(gi);
`ifdef AES_INV_SBOX_EN
        localparam int INV = inv_src_idx(gi);
        assign out_state[BYTE_W*gi +: BYTE_W] = r_inv ? r_work[BYTE_W*INV +: BYTE_W]
                                                      : r_work[BYTE_W*FWD +: BYTE_W];
`else
        assign out_state[BYTE_W*gi +: BYTE_W] = r_work[BYTE_W*FWD +: BYTE_W];
`endif
    end

endmodule

// File: tb/tb_aes_sub_shift.sv
// Self-checking bench for aes_sub_shift; the S-box reference is derived from GF(2^8) arithmetic.
module tb_aes_sub_shift;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
`ifdef AES_INV_SBOX_EN
    logic         in_inv;
`endif

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] m_fwd [256];
    logic [7:0] m_inv [256];

    always #5 clk = ~clk;

    aes_sub_shift dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
`ifdef AES_INV_SBOX_EN
        .in_inv    (in_inv),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] p;
        a = a_in;
        b = b_in;
        p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    // S-box = affine transform of the multiplicative inverse in GF(2^8).
    task automatic build_model();
        logic [7:0] b;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            b = 8'h00;
            if (x != 0)
                for (int y = 1; y < 256; y++)
                    if (gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
            s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
            m_fwd[x] = s;
            m_inv[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] model(input logic [127:0] s, input logic inv);
        logic [7:0]   sub [16];
        logic [127:0] o;
        int           src;
        for (int i = 0; i < 16; i++)
            sub[i] = inv ? m_inv[s[8*i +: 8]] : m_fwd[s[8*i +: 8]];
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                src = inv ? 4 * ((c - r + 4) % 4) + r : 4 * ((c + r) % 4) + r;
                o[8*(4*c + r) +: 8] = sub[src];
            end
        return o;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Accept one state and check the 4-cycle latency; returns with the DUT in DONE.
    task automatic run_one(input string tag, input logic [127:0] st, input logic inv,
                           output logic [127:0] res);
        chk({tag, "/in_ready_idle"}, 128'(in_ready), 128'd1);
        in_state = st;
        in_valid = 1'b1;
`ifdef AES_INV_SBOX_EN
        in_inv   = inv;
`endif
        step();
        in_valid = 1'b0;
        in_state = rnd128();
        chk({tag, "/in_ready_busy"}, 128'(in_ready), 128'd0);
        chk({tag, "/out_valid_e0"}, 128'(out_valid), 128'd0);
        for (int k = 1; k < 4; k++) begin
            step();
            chk($sformatf("%s/out_valid_e%0d", tag, k), 128'(out_valid), 128'd0);
        end
        step();
        chk({tag, "/out_valid_e4"}, 128'(out_valid), 128'd1);
        chk({tag, "/out_state"}, out_state, model(st, inv));
        res = out_state;
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        step();
        chk({tag, "/out_valid_fall"}, 128'(out_valid), 128'd0);
        chk({tag, "/in_ready_back"}, 128'(in_ready), 128'd1);
    endtask

    initial begin
        logic [127:0] st;
        logic [127:0] res;
        logic [127:0] res2;
        logic [127:0] held;

        build_model();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_state  = '0;
        out_ready = 1'b1;
`ifdef AES_INV_SBOX_EN
        in_inv    = 1'b0;
`endif
        step();
        step();
        chk("reset/in_ready", 128'(in_ready), 128'd1);
        chk("reset/out_valid", 128'(out_valid), 128'd0);
        chk("reset/out_state", out_state, 128'd0);
        rst_n = 1'b1;
        step();

        run_one("zero", 128'd0, 1'b0, res);
        chk("zero/all63", res, {16{8'h63}});
        release_out("zero");

        for (int i = 0; i < 16; i++) st[8*i +: 8] = 8'(i);
        run_one("incr", st, 1'b0, res);
        chk("incr/bytes0_3", 128'(res[31:0]), 128'h76676b63);
        release_out("incr");

        out_ready = 1'b0;
        run_one("bp", rnd128(), 1'b0, held);
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_state = rnd128();
            step();
            chk($sformatf("bp/stable%0d", k), out_state, held);
            chk($sformatf("bp/in_ready%0d", k), 128'(in_ready), 128'd0);
            chk($sformatf("bp/out_valid%0d", k), 128'(out_valid), 128'd1);
        end
        in_valid = 1'b0;
        release_out("bp");

        in_state = rnd128();
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("midrst/in_ready", 128'(in_ready), 128'd1);
        chk("midrst/out_valid", 128'(out_valid), 128'd0);
        chk("midrst/out_state", out_state, 128'd0);
        step();
        rst_n = 1'b1;
        step();
        run_one("after_rst", rnd128(), 1'b0, res);
        release_out("after_rst");

        for (int n = 0; n < 8; n++) begin
            run_one($sformatf("rnd%0d", n), rnd128(), 1'b0, res);
            release_out($sformatf("rnd%0d", n));
        end

`ifdef AES_INV_SBOX_EN
        run_one("inv63", {16{8'h63}}, 1'b1, res);
        chk("inv63/zero", res, 128'd0);
        release_out("inv63");
        for (int n = 0; n < 100; n++) begin
            st = rnd128();
            run_one($sformatf("rt_fwd%0d", n), st, 1'b0, res);
            release_out($sformatf("rt_fwd%0d", n));
            run_one($sformatf("rt_inv%0d", n), res, 1'b1, res2);
            release_out($sformatf("rt_inv%0d", n));
            chk($sformatf("roundtrip%0d", n), res2, st);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
